// File: rtl/uart_sync_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo_if
//
// Bundles the data/handshake/status signals of uart_sync_fifo so the UART
// register block and the shift engines can pass a single port around.
//
// Parameters
//   W_DATA  data word width in bits
//   D_FIFO  FIFO depth in words (sets the width of count)
//
// Signals
//   flush        -> FIFO  synchronous clear of contents
//   wr_en        -> FIFO  write request
//   wr_data      -> FIFO  write word
//   rd_en        -> FIFO  read/pop request
//   clr_err      -> FIFO  clear sticky overflow/underflow
//   rd_data      <- FIFO  read word
//   full         <- FIFO  count == D_FIFO
//   empty        <- FIFO  count == 0
//   almost_full  <- FIFO  count >= AF_THRESH
//   almost_empty <- FIFO  count <= AE_THRESH
//   count        <- FIFO  current occupancy
//   overflow     <- FIFO  sticky: write attempted while full
//   underflow    <- FIFO  sticky: read attempted while empty
//
// Modports
//   master : the user of the FIFO (drives requests, observes status)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface uart_sync_fifo_if #(
  parameter int W_DATA = 8,
  parameter int D_FIFO = 16
);
  localparam int CNT_W = $clog2(D_FIFO + 1);

  logic              flush;
  logic              wr_en;
  logic [W_DATA-1:0] wr_data;
  logic              rd_en;
  logic              clr_err;
  logic [W_DATA-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en, clr_err,
    input  rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, clr_err,
    output rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//
// Parametrised synchronous FIFO for the UART TX and RX data paths. Any depth
// of two or more is supported (indices wrap by explicit compare, so depth need
// not be a power of two). Provides an occupancy count, programmable
// almost-full / almost-empty thresholds, synchronous flush and sticky
// overflow / underflow flags.
//
// Optional feature macro: UART_SYNC_FIFO_FWFT_EN
//   undefined : standard mode, rd_data is a register loaded on an accepted
//               read (1-cycle read latency), cleared by reset and flush.
//   defined   : first-word-fall-through, rd_data shows the head word
//               (0 when empty) combinationally from registered state; rd_en
//               pops the word currently shown.
//
// Parameters
//   W_DATA     data word width (>= 1)
//   D_FIFO     depth in words (>= 2)
//   AF_THRESH  almost_full when count >= AF_THRESH (1..D_FIFO)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..D_FIFO-1)
//
// Ports
//   clk    single clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset (memory array is not reset)
//   bus    uart_sync_fifo_if.slave: flush, wr_en, wr_data, rd_en, clr_err in;
//          rd_data, full, empty, almost_full, almost_empty, count,
//          overflow, underflow out. The interface must be instantiated with
//          the same W_DATA and D_FIFO as this module.
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int W_DATA    = 8,
  parameter int D_FIFO    = 16,
  parameter int AF_THRESH = D_FIFO - 2,
  parameter int AE_THRESH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_sync_fifo_if.slave bus
);

  // Guarded so that an illegal depth still elaborates far enough to reach
  // the parameter checks below.
  localparam int IDX_W = (D_FIFO >= 2) ? $clog2(D_FIFO) : 1;
  localparam int CNT_W = $clog2(D_FIFO + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D_FIFO - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(D_FIFO);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_THRESH);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  generate
    if (W_DATA < 1) begin : g_bad_width
      $fatal(1, "uart_sync_fifo: W_DATA must be >= 1");
    end
    if (D_FIFO < 2) begin : g_bad_depth
      $fatal(1, "uart_sync_fifo: D_FIFO must be >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > D_FIFO)) begin : g_bad_af
      $fatal(1, "uart_sync_fifo: AF_THRESH must be in 1..D_FIFO");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > D_FIFO - 1)) begin : g_bad_ae
      $fatal(1, "uart_sync_fifo: AE_THRESH must be in 0..D_FIFO-1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W_DATA-1:0] mem_reg [D_FIFO];

  logic [IDX_W-1:0]  wr_idx_reg,    wr_idx_next;
  logic [IDX_W-1:0]  rd_idx_reg,    rd_idx_next;
  logic [CNT_W-1:0]  count_reg,     count_next;
  logic              overflow_reg,  overflow_next;
  logic              underflow_reg, underflow_next;

  // Status decoded from the registered count only, so every flag refers to
  // the occupancy before the coming edge.
  logic full_flag;
  logic empty_flag;

  assign full_flag  = (count_reg == CNT_FULL);
  assign empty_flag = (count_reg == '0);

  // ---------------------------------------------------------------------------
  // Acceptance and error-event decode
  // ---------------------------------------------------------------------------
  // A write against a full FIFO is dropped even when a read is accepted in
  // the same cycle, and a read against an empty FIFO is rejected even when a
  // write is accepted: both decisions use the pre-edge flags.
  logic wr_acc;
  logic rd_acc;
  logic ovf_evt;
  logic unf_evt;

  assign wr_acc  = bus.wr_en && !full_flag  && !bus.flush;
  assign rd_acc  = bus.rd_en && !empty_flag && !bus.flush;
  assign ovf_evt = bus.wr_en &&  full_flag  && !bus.flush;
  assign unf_evt = bus.rd_en &&  empty_flag && !bus.flush;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_idx_next = wr_idx_reg;
    rd_idx_next = rd_idx_reg;
    count_next  = count_reg;

    if (bus.flush) begin
      wr_idx_next = '0;
      rd_idx_next = '0;
      count_next  = '0;
    end else begin
      // Explicit wrap at D_FIFO-1 keeps non-power-of-two depths correct.
      if (wr_acc) begin
        wr_idx_next = (wr_idx_reg == IDX_LAST) ? '0 : wr_idx_reg + IDX_ONE;
      end
      if (rd_acc) begin
        rd_idx_next = (rd_idx_reg == IDX_LAST) ? '0 : rd_idx_reg + IDX_ONE;
      end

      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  // Sticky error flags: a new event in the same cycle as clr_err wins.
  // Flush leaves them alone (the event terms are already masked by flush).
  always_comb begin
    overflow_next  = ovf_evt || (overflow_reg  && !bus.clr_err);
    underflow_next = unf_evt || (underflow_reg && !bus.clr_err);
  end

  // ---------------------------------------------------------------------------
  // Control/status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_reg    <= '0;
      rd_idx_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_idx_reg    <= wr_idx_next;
      rd_idx_reg    <= rd_idx_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array: no reset so it maps onto block/distributed RAM. Contents
  // left behind by flush or reset are never visible because the indices and
  // count restart from zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_reg[wr_idx_reg] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
`ifdef UART_SYNC_FIFO_FWFT_EN
  // Head word is presented as soon as it is stored; an empty FIFO shows 0 so
  // a flushed or reset FIFO never exposes stale memory.
  assign bus.rd_data = empty_flag ? '0 : mem_reg[rd_idx_reg];
`else
  logic [W_DATA-1:0] rd_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (bus.flush) begin
      rd_data_reg <= '0;
    end else if (rd_acc) begin
      rd_data_reg <= mem_reg[rd_idx_reg];
    end
  end

  assign bus.rd_data = rd_data_reg;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.full         = full_flag;
  assign bus.empty        = empty_flag;
  assign bus.almost_full  = (count_reg >= CNT_AF);
  assign bus.almost_empty = (count_reg <= CNT_AE);
  assign bus.count        = count_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_sync_fifo
//
// Two instances: a 16-deep FIFO (AF=14, AE=1) for fill/drain/flag/flush/reset
// scenarios and a 5-deep FIFO (AF=3, AE=1) for non-power-of-two wrap.
// A queue-based reference model predicts every output; a negedge process
// compares both DUTs against it each cycle, and the directed sequence adds
// hand-computed literal expectations. Works in both read modes.
// -----------------------------------------------------------------------------
module tb_uart_sync_fifo;

  logic clk;
  logic rst_n;

  uart_sync_fifo_if #(.W_DATA(8), .D_FIFO(16)) bus16 ();
  uart_sync_fifo_if #(.W_DATA(8), .D_FIFO(5))  bus5  ();

  uart_sync_fifo #(.W_DATA(8), .D_FIFO(16)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  uart_sync_fifo #(.W_DATA(8), .D_FIFO(5)) u5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue contents, sticky flags, standard-mode read register
  // ---------------------------------------------------------------------------
  logic [7:0] q16[$];
  logic [7:0] q5[$];
  logic       m16_ovf = 1'b0, m16_unf = 1'b0;
  logic       m5_ovf  = 1'b0, m5_unf  = 1'b0;
  logic [7:0] m16_rd  = 8'h00, m5_rd  = 8'h00;

  task automatic model16();
    bit         wa, ra;
    logic [7:0] w;
    wa = bus16.wr_en && !bus16.flush && (q16.size() < 16);
    ra = bus16.rd_en && !bus16.flush && (q16.size() > 0);
    m16_ovf <= (bus16.wr_en && !bus16.flush && q16.size() == 16) || (m16_ovf && !bus16.clr_err);
    m16_unf <= (bus16.rd_en && !bus16.flush && q16.size() == 0)  || (m16_unf && !bus16.clr_err);
    if (bus16.flush) begin
      q16.delete();
      m16_rd <= 8'h00;
    end else begin
      if (ra) begin
        w = q16.pop_front();
        m16_rd <= w;
      end
      if (wa) q16.push_back(bus16.wr_data);
    end
  endtask

  task automatic model5();
    bit         wa, ra;
    logic [7:0] w;
    wa = bus5.wr_en && !bus5.flush && (q5.size() < 5);
    ra = bus5.rd_en && !bus5.flush && (q5.size() > 0);
    m5_ovf <= (bus5.wr_en && !bus5.flush && q5.size() == 5) || (m5_ovf && !bus5.clr_err);
    m5_unf <= (bus5.rd_en && !bus5.flush && q5.size() == 0) || (m5_unf && !bus5.clr_err);
    if (bus5.flush) begin
      q5.delete();
      m5_rd <= 8'h00;
    end else begin
      if (ra) begin
        w = q5.pop_front();
        m5_rd <= w;
      end
      if (wa) q5.push_back(bus5.wr_data);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q16.delete();
      q5.delete();
      m16_ovf <= 1'b0; m16_unf <= 1'b0; m16_rd <= 8'h00;
      m5_ovf  <= 1'b0; m5_unf  <= 1'b0; m5_rd  <= 8'h00;
    end else begin
      model16();
      model5();
    end
  end

  function automatic logic [7:0] exp_rd16();
`ifdef UART_SYNC_FIFO_FWFT_EN
    return (q16.size() == 0) ? 8'h00 : q16[0];
`else
    return m16_rd;
`endif
  endfunction

  function automatic logic [7:0] exp_rd5();
`ifdef UART_SYNC_FIFO_FWFT_EN
    return (q5.size() == 0) ? 8'h00 : q5[0];
`else
    return m5_rd;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Per-cycle compare (away from the active edge)
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("u16_count", 32'(bus16.count),        32'(q16.size()));
      chk("u16_empty", 32'(bus16.empty),        32'(q16.size() == 0));
      chk("u16_full",  32'(bus16.full),         32'(q16.size() == 16));
      chk("u16_af",    32'(bus16.almost_full),  32'(q16.size() >= 14));
      chk("u16_ae",    32'(bus16.almost_empty), 32'(q16.size() <= 1));
      chk("u16_ovf",   32'(bus16.overflow),     32'(m16_ovf));
      chk("u16_unf",   32'(bus16.underflow),    32'(m16_unf));
      chk("u16_rd",    32'(bus16.rd_data),      32'(exp_rd16()));
      chk("u5_count",  32'(bus5.count),         32'(q5.size()));
      chk("u5_empty",  32'(bus5.empty),         32'(q5.size() == 0));
      chk("u5_full",   32'(bus5.full),          32'(q5.size() == 5));
      chk("u5_af",     32'(bus5.almost_full),   32'(q5.size() >= 3));
      chk("u5_ae",     32'(bus5.almost_empty),  32'(q5.size() <= 1));
      chk("u5_ovf",    32'(bus5.overflow),      32'(m5_ovf));
      chk("u5_unf",    32'(bus5.underflow),     32'(m5_unf));
      chk("u5_rd",     32'(bus5.rd_data),       32'(exp_rd5()));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle16();
    bus16.flush = 1'b0; bus16.wr_en = 1'b0; bus16.rd_en = 1'b0; bus16.clr_err = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_count"}, 32'(bus16.count),        32'd0);
    chk({tag, "_empty"}, 32'(bus16.empty),        32'd1);
    chk({tag, "_full"},  32'(bus16.full),         32'd0);
    chk({tag, "_ae"},    32'(bus16.almost_empty), 32'd1);
    chk({tag, "_af"},    32'(bus16.almost_full),  32'd0);
    chk({tag, "_ovf"},   32'(bus16.overflow),     32'd0);
    chk({tag, "_unf"},   32'(bus16.underflow),    32'd0);
    chk({tag, "_rd"},    32'(bus16.rd_data),      32'd0);
  endtask

  logic [7:0] got;

  initial begin
    rst_n = 1'b0;
    idle16();
    bus16.wr_data = 8'h00;
    bus5.flush = 1'b0; bus5.wr_en = 1'b0; bus5.rd_en = 1'b0; bus5.clr_err = 1'b0;
    bus5.wr_data = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    reset_vals("rst");
    #2 rst_n = 1'b1;
    tick();

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      bus16.wr_en = 1'b1; bus16.wr_data = 8'(i);
      tick();
      chk("fill_count", 32'(bus16.count), 32'(i));
      chk("fill_af",    32'(bus16.almost_full), 32'(i >= 14));
    end
    chk("fill_full", 32'(bus16.full), 32'd1);
    bus16.wr_data = 8'hFF;
    tick();
    chk("ovf_set",   32'(bus16.overflow), 32'd1);
    chk("ovf_count", 32'(bus16.count),    32'd16);
    $display("fill: count=%0d overflow=%0d", bus16.count, bus16.overflow);
    bus16.wr_en = 1'b0;

    // Drain, data in order
    bus16.rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
`ifdef UART_SYNC_FIFO_FWFT_EN
      chk("drain_data", 32'(bus16.rd_data), 32'(i));
`endif
      tick();
`ifndef UART_SYNC_FIFO_FWFT_EN
      chk("drain_data", 32'(bus16.rd_data), 32'(i));
`endif
      chk("drain_ae", 32'(bus16.almost_empty), 32'((16 - i) <= 1));
    end
    chk("drain_empty", 32'(bus16.empty), 32'd1);
    tick();
    chk("unf_set", 32'(bus16.underflow), 32'd1);
`ifdef UART_SYNC_FIFO_FWFT_EN
    chk("unf_rd", 32'(bus16.rd_data), 32'h00);
`else
    chk("unf_rd", 32'(bus16.rd_data), 32'h10);
`endif
    $display("drain: empty=%0d underflow=%0d", bus16.empty, bus16.underflow);
    idle16();

    // Clear errors
    bus16.clr_err = 1'b1;
    tick();
    idle16();
    chk("clr_ovf", 32'(bus16.overflow),  32'd0);
    chk("clr_unf", 32'(bus16.underflow), 32'd0);

    // Simultaneous write+read when empty
    bus16.wr_en = 1'b1; bus16.rd_en = 1'b1; bus16.wr_data = 8'h33;
    tick();
    idle16();
    chk("wr_rd_empty_count", 32'(bus16.count),     32'd1);
    chk("wr_rd_empty_unf",   32'(bus16.underflow), 32'd1);
    $display("wr+rd empty: count=%0d underflow=%0d", bus16.count, bus16.underflow);

    // Fill to full, then simultaneous write+read when full
    for (int i = 1; i <= 15; i++) begin
      bus16.wr_en = 1'b1; bus16.wr_data = 8'(8'h40 + i);
      tick();
    end
    chk("refill_full", 32'(bus16.full), 32'd1);
    bus16.wr_en = 1'b1; bus16.rd_en = 1'b1; bus16.wr_data = 8'hEE;
    tick();
    idle16();
    chk("wr_rd_full_count", 32'(bus16.count),    32'd15);
    chk("wr_rd_full_ovf",   32'(bus16.overflow), 32'd1);
`ifdef UART_SYNC_FIFO_FWFT_EN
    chk("wr_rd_full_rd", 32'(bus16.rd_data), 32'h41);
`else
    chk("wr_rd_full_rd", 32'(bus16.rd_data), 32'h33);
`endif
    $display("wr+rd full: count=%0d overflow=%0d", bus16.count, bus16.overflow);

    // Read down to 7, then flush with wr_en
    bus16.rd_en = 1'b1;
    repeat (8) tick();
    idle16();
    chk("pre_flush_count", 32'(bus16.count), 32'd7);
    bus16.flush = 1'b1; bus16.wr_en = 1'b1; bus16.wr_data = 8'h77;
    tick();
    idle16();
    chk("flush_count", 32'(bus16.count),     32'd0);
    chk("flush_empty", 32'(bus16.empty),     32'd1);
    chk("flush_rd",    32'(bus16.rd_data),   32'd0);
    chk("flush_ovf",   32'(bus16.overflow),  32'd1);
    chk("flush_unf",   32'(bus16.underflow), 32'd1);
    $display("flush: count=%0d ovf=%0d unf=%0d", bus16.count, bus16.overflow, bus16.underflow);

    bus16.clr_err = 1'b1;
    tick();
    idle16();
    chk("clr2_ovf", 32'(bus16.overflow), 32'd0);

    // Fill, overflow, then clear coinciding with a new overflow event
    for (int i = 0; i < 16; i++) begin
      bus16.wr_en = 1'b1; bus16.wr_data = 8'(8'h80 + i);
      tick();
    end
    chk("fill2_ovf_clear", 32'(bus16.overflow), 32'd0);
    tick();
    chk("fill2_ovf_set", 32'(bus16.overflow), 32'd1);
    bus16.clr_err = 1'b1;
    tick();
    idle16();
    chk("clr_vs_set_ovf", 32'(bus16.overflow), 32'd1);
    $display("clr vs set: overflow=%0d", bus16.overflow);

    // Half-full simultaneous write+read
    bus16.rd_en = 1'b1;
    repeat (8) tick();
    idle16();
    bus16.wr_en = 1'b1; bus16.rd_en = 1'b1; bus16.wr_data = 8'h99;
    tick();
    idle16();
    chk("wr_rd_half_count", 32'(bus16.count), 32'd8);
    $display("wr+rd half: count=%0d", bus16.count);

    // Async reset mid-stream at count 9
    bus16.wr_en = 1'b1; bus16.wr_data = 8'hC0;
    tick();
    idle16();
    chk("pre_rst_count", 32'(bus16.count), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    reset_vals("async_rst");
    $display("async reset: count=%0d", bus16.count);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    bus16.wr_en = 1'b1; bus16.wr_data = 8'h5A;
    tick();
    idle16();
`ifdef UART_SYNC_FIFO_FWFT_EN
    chk("post_rst_rd", 32'(bus16.rd_data), 32'h5A);
    bus16.rd_en = 1'b1;
    tick();
    idle16();
`else
    bus16.rd_en = 1'b1;
    tick();
    idle16();
    chk("post_rst_rd", 32'(bus16.rd_data), 32'h5A);
`endif
    chk("post_rst_empty", 32'(bus16.empty), 32'd1);
    $display("post reset read: 0x%02h", bus16.rd_data);

    // Depth-5 wrap: 4 writes, 8 write+read, 4 reads (12 words, two wraps)
    for (int k = 0; k < 16; k++) begin
      bus5.wr_en = (k < 12); bus5.wr_data = 8'(8'hA0 + k);
      bus5.rd_en = (k >= 4);
      got = 8'h00;
`ifdef UART_SYNC_FIFO_FWFT_EN
      got = bus5.rd_data;
`endif
      tick();
`ifndef UART_SYNC_FIFO_FWFT_EN
      got = bus5.rd_data;
`endif
      if (k >= 4) begin
        chk("wrap_data", 32'(got), 32'(8'hA0 + (k - 4)));
        $display("wrap read %0d: 0x%02h", k - 4, got);
      end
      if (k == 8) chk("wrap_count", 32'(bus5.count), 32'd4);
    end
    bus5.wr_en = 1'b0; bus5.rd_en = 1'b0;
    chk("wrap_empty", 32'(bus5.empty), 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
